// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   start        launch request, sampled only while idle (busy == 0)
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   busy         high while an operation is in flight (CALC and DONE)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   div_by_zero  registered flag for the last completed operation
//
// A zero-divisor request still spends one cycle in CALC, so its done pulse
// arrives one edge after the accept edge rather than on it.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] rem_q;  // partial remainder; always < divisor after an iteration
    logic [WIDTH-1:0] quo_q;  // dividend shifted out MSB-first, quotient shifted in
    logic [WIDTH-1:0] dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic             dz_q;

    // One restoring iteration on the current working registers.
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]};
        trial_ge = (trial >= {1'b0, dvs_q});
        // When the subtraction is skipped, trial < divisor so its MSB is zero.
        rem_next = trial_ge ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], trial_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        quo_q   <= dividend;
                        rem_q   <= '0;
                        dvs_q   <= divisor;
                        cnt_q   <= '0;
                        dz_q    <= (divisor == '0);
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (dz_q) begin
                        // quo_q still holds the untouched dividend.
                        quotient    <= '1;
                        remainder   <= quo_q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        if (cnt_q == LastCnt) begin
                            quotient    <= quo_next;
                            remainder   <= rem_next;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] dividend = '0;
    logic [4:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_restoring_divider #(.WIDTH(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op from idle, wait (bounded) for done, then check results.
    task automatic run_op(input string tag, input logic [4:0] n, input logic [4:0] d,
                          input logic [4:0] exp_q, input logic [4:0] exp_r,
                          input logic exp_dz, input int exp_lat, input bit chk_timing);
        int lat;
        int busy_low;
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        tick();  // accept edge
        start    = 1'b0;
        lat      = 0;
        busy_low = 0;
        while (!done && lat < 20) begin
            if (!busy) busy_low++;
            tick();
            lat++;
        end
        if (chk_timing) begin
            check_eq({tag, " latency"}, lat, exp_lat);
            check_eq({tag, " busy low cycles"}, busy_low, 0);
            check_eq({tag, " busy at done"}, busy, 1);
        end else begin
            check_eq({tag, " done seen"}, done, 1);
        end
        check_eq({tag, " q"}, quotient, exp_q);
        check_eq({tag, " r"}, remainder, exp_r);
        check_eq({tag, " dz"}, div_by_zero, exp_dz);
        tick();
        if (chk_timing) begin
            check_eq({tag, " done width"}, done, 0);
            check_eq({tag, " busy after"}, busy, 0);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int gap;
        logic [4:0] eq;
        logic [4:0] er;

        // Reset state
        #2;
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst q", quotient, 0);
        check_eq("rst r", remainder, 0);
        check_eq("rst dz", div_by_zero, 0);
        #20;
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_op("23/5", 5'd23, 5'd5, 5'd4, 5'd3, 1'b0, 5, 1'b1);
        tick();
        tick();
        check_eq("hold q in idle", quotient, 4);
        check_eq("hold r in idle", remainder, 3);
        run_op("31/1", 5'd31, 5'd1, 5'd31, 5'd0, 1'b0, 5, 1'b1);
        run_op("7/9", 5'd7, 5'd9, 5'd0, 5'd7, 1'b0, 5, 1'b1);
        run_op("0/3", 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 5, 1'b1);
        run_op("31/31", 5'd31, 5'd31, 5'd1, 5'd0, 1'b0, 5, 1'b1);
        run_op("13/0", 5'd13, 5'd0, 5'd31, 5'd13, 1'b1, 1, 1'b1);
        run_op("10/3", 5'd10, 5'd3, 5'd3, 5'd1, 1'b0, 5, 1'b1);

        // start pulses while busy must be ignored
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();  // after edge 2
        dividend = 5'd20;
        divisor  = 5'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();  // after edge 4
        start = 1'b1;
        tick();  // after edge 5: DONE
        start = 1'b0;
        check_eq("ign done", done, 1);
        check_eq("ign q", quotient, 4);
        check_eq("ign r", remainder, 3);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check_eq("ign extra done", pulses, 0);
        check_eq("ign busy", busy, 0);

        // Async reset mid-CALC after a divide by zero set the flag
        run_op("13/0 again", 5'd13, 5'd0, 5'd31, 5'd13, 1'b1, 1, 1'b0);
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();  // two iterations done
        rst_n = 1'b0;
        #1;
        check_eq("mid rst busy", busy, 0);
        check_eq("mid rst done", done, 0);
        check_eq("mid rst q", quotient, 0);
        check_eq("mid rst r", remainder, 0);
        check_eq("mid rst dz", div_by_zero, 0);
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check_eq("no done after rst", pulses, 0);
        run_op("9/2", 5'd9, 5'd2, 5'd4, 5'd1, 1'b0, 5, 1'b1);

        // start held high: relaunch on first idle cycle, 7 cycles per op
        dividend = 5'd6;
        divisor  = 5'd2;
        start    = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("b2b first lat", lat, 5);
        tick();
        gap = 1;
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        start = 1'b0;
        check_eq("b2b gap", gap, 7);
        check_eq("b2b q", quotient, 3);
        lat = 0;
        while (busy && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("b2b idle", busy, 0);

        // Sweep every operand pair against a reference model
        for (int n = 0; n < 32; n++) begin
            for (int d = 0; d < 32; d++) begin
                if (d == 0) begin
                    eq = 5'd31;
                    er = 5'(n);
                end else begin
                    eq = 5'(n / d);
                    er = 5'(n % d);
                end
                run_op($sformatf("sweep %0d/%0d", n, d), 5'(n), 5'(d), eq, er,
                       (d == 0), 0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
